serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor built from a chain of 1-bit full-adder cells.
- Each operand pair is processed BPC bits per clock, LSB first, with the carry held in a flop between steps.
- Valid/ready handshakes on both the input and output sides.
- Successor to the single-bit combinational full adder; used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fa_cell.sv | 14 +
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and parameter helpers for the serial adder/subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   function automatic int steps(input int width, input int bpc);
      return width / bpc;
   endfunction

   function automatic bit bpc_divides(input int width, input int bpc);
      return (width >= 1) && (bpc >= 1) && ((width % bpc) == 0);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// 1-bit full adder cell, chained inside one serial step.
// Purely combinational; no handshake.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BPC bits per clock, LSB first, carry held in a flop.
// Latency WIDTH/BPC clocks from accept to out_valid; holds result until out_ready, one op in flight.
// SERIAL_ADDER_OVF_EN adds the Ovf (signed overflow) output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int S  = steps(WIDTH, BPC);
   localparam int CW = $clog2(S + 1);

   if (!bpc_divides(WIDTH, BPC)) begin : g_param_check
      $error("serial_adder: BPC must divide WIDTH");
   end

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   logic [BPC:0]     c;
   logic [BPC-1:0]   step_s;
   logic [WIDTH-1:0] step_w;
   logic [WIDTH-1:0] sum_nxt;
   logic             last;

   assign c[0] = carry_r;

   for (genvar i = 0; i < BPC; i++) begin : g_cell
      fa_cell u_fa (
         .a  (a_sh[i]),
         .b  (b_sh[i]),
         .ci (c[i]),
         .s  (step_s[i]),
         .co (c[i+1])
      );
   end

   // New result bits enter at the top so the word is LSB-aligned after S steps.
   always_comb begin
      step_w = '0;
      step_w[BPC-1:0] = step_s;
   end

   assign sum_nxt = (sum_sh >> BPC) | (step_w << (WIDTH - BPC));
   assign last    = (cnt == CW'(S - 1));

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;
   assign Ovf = ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_r <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= A;
                  b_sh    <= Sub ? ~B : B;
                  carry_r <= Sub ? 1'b1 : Cin;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> BPC;
               b_sh    <= b_sh >> BPC;
               sum_sh  <= sum_nxt;
               carry_r <= c[BPC];
               cnt     <= cnt + CW'(1);
               if (last) begin
                  // Outputs only move here so Sum stays put through IDLE and RUN.
                  sum_q   <= sum_nxt;
                  carry_q <= c[BPC];
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q   <= c[BPC] ^ c[BPC-1];
`endif
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign Sum       = sum_q;
   assign Carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit/1-bpc and 16-bit/4-bpc instances.
module tb_serial_adder;

   typedef struct packed {
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       in_valid = 1'b0, out_ready = 1'b0, Cin = 1'b0, Sub = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       in_ready, out_valid, Carry;
   logic [7:0] Sum;
   // 16-bit instance
   logic        iv16 = 1'b0, or16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ir16, ov16, carry16;
   logic [15:0] sum16;
`ifdef SERIAL_ADDER_OVF_EN
   logic Ovf, ovf16;
`endif

   serial_adder #(.WIDTH(8), .BPC(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub),
      .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Carry(Carry)
`ifdef SERIAL_ADDER_OVF_EN
      , .Ovf(Ovf)
`endif
   );

   serial_adder #(.WIDTH(16), .BPC(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .A(a16), .B(b16), .Cin(cin16), .Sub(sub16),
      .out_valid(ov16), .out_ready(or16), .Sum(sum16), .Carry(carry16)
`ifdef SERIAL_ADDER_OVF_EN
      , .Ovf(ovf16)
`endif
   );

   int   total_cnt = 0;
   int   pass_cnt  = 0;
   exp_t q8[$];
   exp_t q16[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitors: consume expectations whenever a result is taken.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (q8.size() == 0) check("unexpected_out8", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            check("sum8", {24'd0, Sum}, {16'd0, e.sum});
            check("carry8", {31'd0, Carry}, {31'd0, e.carry});
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf8", {31'd0, Ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ov16 && or16) begin
         if (q16.size() == 0) check("unexpected_out16", 32'd1, 32'd0);
         else begin
            e = q16.pop_front();
            check("sum16", {16'd0, sum16}, {16'd0, e.sum});
            check("carry16", {31'd0, carry16}, {31'd0, e.carry});
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf16", {31'd0, ovf16}, {31'd0, e.ovf});
`endif
         end
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input int hold, input bit keep_valid);
      int n;
      bit busy_bad;
      A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("accept_wait8", n, 0);
      q8.push_back('{sum: {8'd0, es}, carry: ec, ovf: eo});
      @(posedge clk); #1;
      // Scramble the ports: the operation in flight must not see them.
      A = ~a; B = ~b; Cin = ~cin; Sub = ~sub; in_valid = keep_valid;
      n = 0; busy_bad = 0;
      while (!out_valid && n < 40) begin
         if (in_ready) busy_bad = 1;
         @(posedge clk); #1; n++;
      end
      check("latency8", n, 8);
      check("in_ready_busy8", {31'd0, busy_bad}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid8", {31'd0, out_valid}, 32'd1);
         check("hold_sum8", {24'd0, Sum}, {24'd0, es});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drop_valid8", {31'd0, out_valid}, 32'd0);
      check("idle_ready8", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo);
      int n;
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
      n = 0;
      while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
      check("accept_wait16", n, 0);
      q16.push_back('{sum: es, carry: ec, ovf: eo});
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = '0; b16 = '0;
      n = 0;
      while (!ov16 && n < 40) begin @(posedge clk); #1; n++; end
      check("latency16", n, 4);
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      check("drop_valid16", {31'd0, ov16}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {24'd0, Sum}, 32'd0);
      check("rst_carry", {31'd0, Carry}, 32'd0);
      check("rst_in_ready16", {31'd0, ir16}, 32'd1);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      //    A      B      Cin   Sub   Sum    C     Ovf
      op8(8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 0, 0);
      op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
      op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
      op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 0);
      op8(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 0, 0);
      op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 0);
      op8(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0);
      // Backpressure: 5 stalled cycles, in_valid held high through DONE.
      op8(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5, 1);
      op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0, 0);

      // Abort at RUN step 3 with an asynchronous reset.
      A = 8'h11; B = 8'h22; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_sum", {24'd0, Sum}, 32'd0);
      check("abort_carry", {31'd0, Carry}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0, 0);

      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("q8_drained", q8.size(), 0);
      check("q16_drained", q16.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
